alu_arbiter: RTL and testbench

Shares the single registered ALU (one-cycle latency, result on `res` the cycle after operands are presented) between two requesters. Requester 0 is the integer execute stage; requester 1 is the address-generation/branch-compare path. The block grants round-robin, drives the ALU operand/opcode inputs, tracks the in-flight operation, and buffers each requester's result behind a valid/ready response handshake.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 37 +++
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: funct encodings, requester indices and default width.
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;

    // RV64I funct3 encodings
    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_SLTU   = 3'b011;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_SRLSRA = 3'b101;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    localparam logic [6:0] F7_SUB = 7'b0100000;

    // Requester indices
    localparam int unsigned REQ_EXE = 0;
    localparam int unsigned REQ_AGU = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the pointer names who wins when both ask.
module rr_arb2 (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] elig_req,
    input  logic       fire,
    output logic [1:0] grant,
    output logic       ptr
);

    logic ptr_q, ptr_d;

    // Pick the pointed requester on contention, else the lone asker; advance only on fire.
    always_comb begin
        grant = elig_req;
        if (elig_req == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
        ptr_d = ptr_q;
        if (fire) begin
            // Pointer moves to the requester that did not just win.
            ptr_d = grant[0];
        end
    end

    // Priority pointer register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between the execute stage and the AGU/branch path,
// tracking the in-flight op and buffering each requester's result.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = alu_pkg::XLEN_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [1:0]      req_imm,
    input  logic [XLEN-1:0] req0_op1,
    input  logic [XLEN-1:0] req0_op2,
    input  logic [XLEN-1:0] req1_op1,
    input  logic [XLEN-1:0] req1_op2,
    input  logic [2:0]      req0_funct3,
    input  logic [2:0]      req1_funct3,
    input  logic [6:0]      req0_funct7,
    input  logic [6:0]      req1_funct7,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [XLEN-1:0] rsp0_data,
    output logic [XLEN-1:0] rsp1_data,
    output logic            alu_imm,
    output logic [XLEN-1:0] alu_op1,
    output logic [XLEN-1:0] alu_op2,
    output logic [2:0]      alu_funct3,
    output logic [6:0]      alu_funct7,
    input  logic [XLEN-1:0] alu_res
);

    logic [1:0]      inflight_q, inflight_d;
    logic [1:0]      slot_full_q, slot_full_d;
    logic [XLEN-1:0] slot0_q, slot0_d;
    logic [XLEN-1:0] slot1_q, slot1_d;
    logic [1:0]      elig, elig_req, grant, fire;
    logic            ptr;

    // Eligibility and ready; ready ignores the requester's own valid so it can't loop back.
    always_comb begin
        elig = 2'b00;
        for (int i = 0; i < 2; i++) begin
            // A full slot still admits an issue if it drains this cycle.
            elig[i] = !RST && !inflight_q[i] && (!slot_full_q[i] || rsp_ready[i]);
        end
        elig_req = req_valid & elig;
        req_ready[REQ_EXE] = elig[REQ_EXE] && (!elig_req[REQ_AGU] || !ptr);
        req_ready[REQ_AGU] = elig[REQ_AGU] && (!elig_req[REQ_EXE] || ptr);
        fire = req_valid & req_ready;
    end

    rr_arb2 u_arb (
        .CLK      (CLK),
        .RST      (RST),
        .elig_req (elig_req),
        .fire     (|fire),
        .grant    (grant),
        .ptr      (ptr)
    );

    // Operand mux onto the ALU; idle cycles present ADD 0+0 whose result is discarded.
    always_comb begin
        alu_imm    = 1'b0;
        alu_op1    = '0;
        alu_op2    = '0;
        alu_funct3 = 3'b000;
        alu_funct7 = 7'b0000000;
        unique case (grant)
            2'b01: begin
                alu_imm    = req_imm[REQ_EXE];
                alu_op1    = req0_op1;
                alu_op2    = req0_op2;
                alu_funct3 = req0_funct3;
                alu_funct7 = req0_funct7;
            end
            2'b10: begin
                alu_imm    = req_imm[REQ_AGU];
                alu_op1    = req1_op1;
                alu_op2    = req1_op2;
                alu_funct3 = req1_funct3;
                alu_funct7 = req1_funct7;
            end
            default: ;
        endcase
    end

    // In-flight tracking and result slots; a refill in the drain cycle keeps the slot full.
    always_comb begin
        inflight_d  = grant;
        slot_full_d = slot_full_q & ~(slot_full_q & rsp_ready);
        slot0_d     = slot0_q;
        slot1_d     = slot1_q;
        if (inflight_q[REQ_EXE]) begin
            slot_full_d[REQ_EXE] = 1'b1;
            slot0_d              = alu_res;
        end
        if (inflight_q[REQ_AGU]) begin
            slot_full_d[REQ_AGU] = 1'b1;
            slot1_d              = alu_res;
        end
    end

    // State registers; reset drops in-flight ops and buffered results.
    always_ff @(posedge CLK) begin
        if (RST) begin
            inflight_q  <= 2'b00;
            slot_full_q <= 2'b00;
            slot0_q     <= '0;
            slot1_q     <= '0;
        end else begin
            inflight_q  <= inflight_d;
            slot_full_q <= slot_full_d;
            slot0_q     <= slot0_d;
            slot1_q     <= slot1_d;
        end
    end

    assign rsp_valid = slot_full_q;
    assign rsp0_data = slot0_q;
    assign rsp1_data = slot1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural registered ALU attached.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int unsigned XLEN = 64;

    logic            CLK = 1'b0;
    logic            RST;
    logic [1:0]      req_valid, req_ready, req_imm;
    logic [XLEN-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [2:0]      req0_funct3, req1_funct3;
    logic [6:0]      req0_funct7, req1_funct7;
    logic [1:0]      rsp_valid, rsp_ready;
    logic [XLEN-1:0] rsp0_data, rsp1_data;
    logic            alu_imm;
    logic [XLEN-1:0] alu_op1, alu_op2, alu_res;
    logic [2:0]      alu_funct3;
    logic [6:0]      alu_funct7;

    int n_checks = 0;
    int n_errors = 0;

    alu_arbiter #(.XLEN(XLEN)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_imm     (req_imm),
        .req0_op1    (req0_op1),
        .req0_op2    (req0_op2),
        .req1_op1    (req1_op1),
        .req1_op2    (req1_op2),
        .req0_funct3 (req0_funct3),
        .req1_funct3 (req1_funct3),
        .req0_funct7 (req0_funct7),
        .req1_funct7 (req1_funct7),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp0_data   (rsp0_data),
        .rsp1_data   (rsp1_data),
        .alu_imm     (alu_imm),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_funct3  (alu_funct3),
        .alu_funct7  (alu_funct7),
        .alu_res     (alu_res)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] alu_f(input logic imm, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [63:0] a,
                                          input logic [63:0] b);
        case (f3)
            F3_ADDSUB: alu_f = (!imm && f7 == F7_SUB) ? a - b : a + b;
            F3_SLL:    alu_f = a << b[5:0];
            F3_SLT:    alu_f = {63'd0, $signed(a) < $signed(b)};
            F3_SLTU:   alu_f = {63'd0, a < b};
            F3_XOR:    alu_f = a ^ b;
            F3_SRLSRA: alu_f = f7[5] ? 64'($signed(a) >>> b[5:0]) : a >> b[5:0];
            F3_OR:     alu_f = a | b;
            default:   alu_f = a & b;
        endcase
    endfunction

    // Registered ALU model: result appears the cycle after operands.
    always @(posedge CLK) alu_res <= alu_f(alu_imm, alu_funct3, alu_funct7, alu_op1, alu_op2);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic alu_idle(input string tag);
        check_eq({tag, "_op1"}, alu_op1, 64'd0);
        check_eq({tag, "_op2"}, alu_op2, 64'd0);
        check_eq({tag, "_ctl"}, {53'd0, alu_imm, alu_funct3, alu_funct7}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; req_valid = 2'b00; req_imm = 2'b00; rsp_ready = 2'b11;
        req0_op1 = '0; req0_op2 = '0; req1_op1 = '0; req1_op2 = '0;
        req0_funct3 = '0; req1_funct3 = '0; req0_funct7 = '0; req1_funct7 = '0;
        repeat (3) next_cycle();
        #1;
        check_eq("rst_ready", 64'(req_ready), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp0", rsp0_data, 64'd0);
        check_eq("rst_rsp1", rsp1_data, 64'd0);
        alu_idle("rst_alu");

        // Single request: SUB 5-3
        next_cycle(); RST = 1'b0; #1;
        check_eq("idle_ready", 64'(req_ready), 64'd3);
        next_cycle();
        req_valid = 2'b01; req0_op1 = 64'd5; req0_op2 = 64'd3;
        req0_funct3 = F3_ADDSUB; req0_funct7 = F7_SUB; #1;
        check_eq("single_ready", 64'(req_ready[0]), 64'd1);
        check_eq("single_op1", alu_op1, 64'd5);
        check_eq("single_f7", 64'(alu_funct7), 64'h20);
        next_cycle(); req_valid = 2'b00; #1;
        check_eq("single_c2_valid", 64'(rsp_valid), 64'd0);
        check_eq("single_c2_ready0", 64'(req_ready[0]), 64'd0);
        next_cycle(); #1;
        check_eq("single_c3_valid", 64'(rsp_valid), 64'd1);
        check_eq("single_c3_data", rsp0_data, 64'd2);
        next_cycle(); #1;
        check_eq("single_c4_valid", 64'(rsp_valid), 64'd0);

        // Contention after reset (pointer was left at 1)
        next_cycle(); RST = 1'b1;
        next_cycle();
        next_cycle(); RST = 1'b0;
        req0_op1 = 64'd10; req0_op2 = 64'd20; req0_funct3 = F3_ADDSUB; req0_funct7 = 7'd0;
        req1_op1 = 64'hF0; req1_op2 = 64'h0F; req1_funct3 = F3_XOR; req1_funct7 = 7'd0;
        req_valid = 2'b11; #1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                next_cycle(); #1;
            end
            check_eq($sformatf("cont%0d_op1", k), alu_op1, (k % 2 == 0) ? 64'd10 : 64'hF0);
            check_eq($sformatf("cont%0d_ready", k), 64'(req_ready),
                     (k % 2 == 0) ? 64'd1 : 64'd2);
            if (k >= 2) begin
                check_eq($sformatf("cont%0d_rspv", k), 64'(rsp_valid),
                         (k % 2 == 0) ? 64'd1 : 64'd2);
                if (k % 2 == 0) check_eq($sformatf("cont%0d_d0", k), rsp0_data, 64'd30);
                else            check_eq($sformatf("cont%0d_d1", k), rsp1_data, 64'hFF);
            end
        end
        next_cycle(); req_valid = 2'b00;
        repeat (3) next_cycle();

        // Backpressure on requester 0: SLL 1<<1
        rsp_ready = 2'b10; req_valid = 2'b01;
        req0_op1 = 64'd1; req0_op2 = 64'd1; req0_funct3 = F3_SLL; req0_funct7 = 7'd0; #1;
        check_eq("bp0_ready0", 64'(req_ready[0]), 64'd1);
        check_eq("bp0_f3", 64'(alu_funct3), 64'd1);
        next_cycle(); req_valid = 2'b10;
        req1_op1 = 64'h100; req1_op2 = 64'h23; req1_funct3 = F3_OR; #1;
        check_eq("bp1_op1", alu_op1, 64'h100);
        check_eq("bp1_ready0", 64'(req_ready[0]), 64'd0);
        for (int k = 2; k <= 6; k++) begin
            next_cycle(); #1;
            check_eq($sformatf("bp%0d_v0", k), 64'(rsp_valid[0]), 64'd1);
            check_eq($sformatf("bp%0d_d0", k), rsp0_data, 64'd2);
            check_eq($sformatf("bp%0d_ready0", k), 64'(req_ready[0]), 64'd0);
            check_eq($sformatf("bp%0d_op1", k), alu_op1, (k % 2 == 1) ? 64'h100 : 64'd0);
            if (k % 2 == 1) check_eq($sformatf("bp%0d_d1", k), rsp1_data, 64'h123);
        end

        // Drain and reissue in the same cycle: ADD 7+4
        next_cycle();
        rsp_ready = 2'b11; req_valid = 2'b01;
        req0_op1 = 64'd7; req0_op2 = 64'd4; req0_funct3 = F3_ADDSUB; #1;
        check_eq("dr0_ready0", 64'(req_ready[0]), 64'd1);
        check_eq("dr0_v0", 64'(rsp_valid[0]), 64'd1);
        check_eq("dr0_d0", rsp0_data, 64'd2);
        check_eq("dr0_op1", alu_op1, 64'd7);
        next_cycle(); req_valid = 2'b00; #1;
        check_eq("dr1_v0", 64'(rsp_valid[0]), 64'd0);
        next_cycle(); #1;
        check_eq("dr2_v0", 64'(rsp_valid[0]), 64'd1);
        check_eq("dr2_d0", rsp0_data, 64'd11);
        repeat (2) next_cycle();

        // Reset the cycle after a requester-1 issue
        req_valid = 2'b10; req1_op1 = 64'd9; req1_op2 = 64'd9; req1_funct3 = F3_ADDSUB; #1;
        check_eq("rm0_ready1", 64'(req_ready[1]), 64'd1);
        next_cycle(); RST = 1'b1; req_valid = 2'b00; #1;
        check_eq("rm1_ready", 64'(req_ready), 64'd0);
        alu_idle("rm1_alu");
        next_cycle(); #1;
        check_eq("rm2_rspv", 64'(rsp_valid), 64'd0);
        check_eq("rm2_ready", 64'(req_ready), 64'd0);
        alu_idle("rm2_alu");
        next_cycle(); RST = 1'b0; req_valid = 2'b11;
        req0_op1 = 64'h55; req1_op1 = 64'h66; #1;
        check_eq("rm3_op1", alu_op1, 64'h55);
        check_eq("rm3_ready", 64'(req_ready), 64'd1);
        check_eq("rm3_rspv", 64'(rsp_valid), 64'd0);
        next_cycle(); req_valid = 2'b00;
        repeat (3) next_cycle();

        // Idle: nothing moves, pointer still favours requester 1
        for (int k = 0; k < 10; k++) begin
            next_cycle(); #1;
            alu_idle($sformatf("idle%0d", k));
            check_eq($sformatf("idle%0d_rspv", k), 64'(rsp_valid), 64'd0);
        end
        next_cycle(); req_valid = 2'b11; #1;
        check_eq("post_idle_op1", alu_op1, 64'h66);
        check_eq("post_idle_ready", 64'(req_ready), 64'd2);
        next_cycle(); req_valid = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
